// File: rtl/ff_pkg.sv
// Shared types and Q16.16 constants for the Forward-Forward goodness path.
package ff_pkg;
    localparam int          Q_FRAC_BITS   = 16;
    localparam logic [31:0] Q_THR_DEFAULT = 32'h0002_0000;

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, REPORT} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_LAYERS = 4,
    localparam int LW = $clog2(NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0] req,
    input  logic [LW-1:0]         ptr,
    output logic [LW-1:0]         idx,
    output logic                  valid
);
    logic [LW:0]   sum;
    logic [LW-1:0] cand;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (LW+1)'(i);
            if (sum >= (LW+1)'(NUM_LAYERS))
                sum = sum - (LW+1)'(NUM_LAYERS);
            cand = sum[LW-1:0];
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/goodness_scheduler.sv
// Shares one goodness_calc between layer requesters: round-robin grant, start,
// wait for done (with watchdog), threshold compare and one-cycle ack.
module goodness_scheduler
    import ff_pkg::*;
#(
    parameter int NUM_LAYERS  = 4,
    parameter int NUM_NEURONS = 256,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT     = NUM_NEURONS + 16,
    localparam int LW = $clog2(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_LAYERS-1:0] req,
    input  logic [NUM_LAYERS-1:0] is_pos,
    input  logic [DATA_WIDTH-1:0] thr,
    output logic [NUM_LAYERS-1:0] ack,
    output logic [DATA_WIDTH-1:0] res_goodness,
    output logic                  res_above,
    output logic                  res_pos,
    output logic [LW-1:0]         res_layer,
    output logic                  res_err,
    output logic                  err_sticky,
    input  logic                  clr_err,
    output logic [LW-1:0]         sel,
    output logic                  gc_start,
    input  logic                  gc_done,
    input  logic [DATA_WIDTH-1:0] gc_goodness,
    output logic                  busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    sched_state_t          state;
    logic [LW-1:0]         ptr;
    logic [DATA_WIDTH-1:0] thr_q;
    logic                  pos_q;
    logic [CW-1:0]         cnt;
    logic [LW-1:0]         arb_idx;
    logic                  arb_valid;
    logic                  timeout_hit;
    logic [NUM_LAYERS-1:0] sel_onehot;

    rr_arbiter #(.NUM_LAYERS(NUM_LAYERS)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
    assign busy        = (state != IDLE);

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            thr_q        <= '0;
            pos_q        <= 1'b0;
            cnt          <= '0;
            sel          <= '0;
            gc_start     <= 1'b0;
            ack          <= '0;
            res_goodness <= '0;
            res_above    <= 1'b0;
            res_pos      <= 1'b0;
            res_layer    <= '0;
            res_err      <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            ack      <= '0;
            gc_start <= 1'b0;
            // A timeout later in this block overrides the clear.
            if (clr_err)
                err_sticky <= 1'b0;
            case (state)
                IDLE: if (arb_valid) begin
                    sel   <= arb_idx;
                    pos_q <= is_pos[arb_idx];
                    thr_q <= thr;
                    state <= SETUP;
                end
                SETUP: begin
                    gc_start <= 1'b1;
                    state    <= START;
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (gc_done) begin
                        res_goodness <= gc_goodness;
                        res_above    <= $signed(gc_goodness) > $signed(thr_q);
                        res_err      <= 1'b0;
                    end else if (timeout_hit) begin
                        res_goodness <= '0;
                        res_above    <= 1'b0;
                        res_err      <= 1'b1;
                        err_sticky   <= 1'b1;
                    end
                    if (gc_done || timeout_hit) begin
                        res_pos   <= pos_q;
                        res_layer <= sel;
                        ack       <= sel_onehot;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    ptr   <= (sel == LW'(NUM_LAYERS - 1)) ? '0 : sel + LW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_goodness_scheduler.sv
// Scoreboard bench for goodness_scheduler with a behavioural calculator model.
module tb_goodness_scheduler;
    localparam int NL = 4;
    localparam int NN = 256;
    localparam int DW = 32;
    localparam int TO = NN + 16;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [NL-1:0] req = '0, is_pos = '0;
    logic [DW-1:0] thr = '0, gc_goodness = '0;
    logic          clr_err = 1'b0, gc_done = 1'b0;
    logic [NL-1:0] ack;
    logic [DW-1:0] res_goodness;
    logic          res_above, res_pos, res_err, err_sticky, gc_start, busy;
    logic [1:0]    res_layer, sel;

    goodness_scheduler #(.NUM_LAYERS(NL), .NUM_NEURONS(NN), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .is_pos(is_pos), .thr(thr),
        .ack(ack), .res_goodness(res_goodness), .res_above(res_above),
        .res_pos(res_pos), .res_layer(res_layer), .res_err(res_err),
        .err_sticky(err_sticky), .clr_err(clr_err), .sel(sel),
        .gc_start(gc_start), .gc_done(gc_done), .gc_goodness(gc_goodness),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          layer;
        logic [31:0] good;
        bit          above, pos, err, sticky;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0;
    int          cnt[NL], rem[NL], lg_delay[NL];
    logic [31:0] lg_good[NL];
    int          mptr = 0;
    bit          msticky = 1'b0;
    bit          force_done = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic logic [63:0] outs();
        return {ack, res_goodness, res_above, res_pos, res_layer, res_err,
                err_sticky, sel, gc_start, busy};
    endfunction

    // Calculator model: done arrives lg_delay cycles after the start pulse (never if <1).
    int done_at = -1;
    always @(negedge clk) begin
        gc_done     = 1'b0;
        gc_goodness = $urandom;
        if (!rst_n) done_at = -1;
        else begin
            if (force_done) begin
                gc_done    = 1'b1;
                force_done = 1'b0;
            end
            if (done_at == cyc) begin
                gc_done     = 1'b1;
                gc_goodness = lg_good[sel];
                done_at     = -1;
            end
            if (gc_start && lg_delay[sel] >= 1) done_at = cyc + lg_delay[sel];
        end
    end

    // Requesters hold req until their last ack, re-requesting immediately.
    always @(negedge clk) begin
        for (int i = 0; i < NL; i++)
            if (ack[i]) begin
                if (rem[i] > 0) rem[i]--;
                if (rem[i] == 0) req[i] = 1'b0;
            end
    end

    // Monitor: pops one expectation per ack and tracks sel/start behaviour per grant.
    int   starts = 0;
    bit   sel_bad = 1'b0, busy_prev = 1'b0;
    logic [1:0] sel0 = '0;
    exp_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            starts = 0; sel_bad = 1'b0; busy_prev = 1'b0;
        end else begin
            if (busy && !busy_prev) sel0 = sel;
            else if (busy && sel != sel0) sel_bad = 1'b1;
            if (gc_start) starts++;
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack: got ack=%b want none", ack);
                end else begin
                    e = sb.pop_front();
                    check("ack_onehot", ack, 64'(1) << e.layer);
                    check("ack_cycle", cyc, e.at);
                    check("result", {res_goodness, res_above, res_pos, res_err, res_layer},
                          {e.good, e.above, e.pos, e.err, 2'(e.layer)});
                    check("err_sticky", err_sticky, e.sticky);
                    check("sel_start", {sel_bad, 8'(starts), sel}, {1'b0, 8'd1, 2'(e.layer)});
                end
                starts = 0; sel_bad = 1'b0;
            end
            busy_prev = busy;
        end
    end

    // Predicts the full grant sequence from the request counts, then drives it.
    task automatic run_scn(input bit clr_hold);
        int left[NL];
        int p, g, lat, i;
        bit err, any;
        exp_t x;
        @(negedge clk);
        p = mptr; g = cyc;
        for (int j = 0; j < NL; j++) left[j] = cnt[j];
        while (1) begin
            any = 1'b0;
            for (int j = 0; j < NL; j++) if (left[j] > 0) any = 1'b1;
            if (!any) break;
            i = p;
            while (left[i] == 0) i = (i + 1) % NL;
            err     = (lg_delay[i] < 1) || (lg_delay[i] > TO);
            lat     = err ? TO + 3 : lg_delay[i] + 3;
            x.layer = i;
            x.err   = err;
            x.good  = err ? 32'h0 : lg_good[i];
            x.above = !err && ($signed(lg_good[i]) > $signed(thr));
            x.pos   = is_pos[i];
            msticky = err ? 1'b1 : (clr_hold ? 1'b0 : msticky);
            x.sticky = msticky;
            x.at    = g + lat;
            sb.push_back(x);
            g = x.at + 1;
            left[i]--;
            p = (i + 1) % NL;
        end
        mptr = p;
        for (int j = 0; j < NL; j++) begin
            rem[j] = cnt[j];
            req[j] = (cnt[j] > 0);
        end
        for (int k = 0; k < 20000 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            total++; bad++;
            $display("FAIL scn_timeout: %0d results outstanding, want 0", sb.size());
            sb.delete();
            req = '0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic set_one(input int l, input logic [31:0] g, input int d);
        for (int j = 0; j < NL; j++) begin
            cnt[j] = 0; rem[j] = 0; lg_delay[j] = NN + 3;
        end
        cnt[l] = 1; lg_good[l] = g; lg_delay[l] = d;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int j = 0; j < NL; j++) begin
            cnt[j] = 0; rem[j] = 0; lg_delay[j] = NN + 3; lg_good[j] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request on layer 1.
        is_pos = 4'b0010; thr = 32'h0002_0000;
        set_one(1, 32'h0003_0000, NN + 3);
        run_scn(1'b0);
        // Threshold equality, then negative threshold.
        set_one(2, 32'h0002_0000, NN + 3);
        run_scn(1'b0);
        thr = 32'hFFFF_0000;
        set_one(3, 32'h0000_0000, NN + 3);
        run_scn(1'b0);

        // Fairness: all four request, layer 0 twice.
        thr = 32'h0002_0000; is_pos = 4'b0101;
        for (int j = 0; j < NL; j++) begin
            cnt[j] = 1; lg_good[j] = $urandom; lg_delay[j] = NN + 3;
        end
        cnt[0] = 2;
        run_scn(1'b0);

        // Timeout, stray done in IDLE, then clear.
        set_one(0, 32'h1234_5678, -1);
        run_scn(1'b0);
        force_done = 1'b1;
        repeat (10) @(negedge clk);
        check("stray_done_idle", busy, 1'b0);
        check("sticky_after_timeout", err_sticky, 1'b1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        msticky = 1'b0;
        check("sticky_cleared", err_sticky, 1'b0);

        // Done on the timeout cycle wins; clr_err held through a timeout loses.
        set_one(1, 32'h0005_0000, TO);
        run_scn(1'b0);
        clr_err = 1'b1;
        set_one(2, 32'h0, -1);
        run_scn(1'b1);
        clr_err = 1'b0;
        msticky = 1'b0;
        check("sticky_clr_after_report", err_sticky, 1'b0);

        // Reset mid-WAIT with a non-zero pointer.
        set_one(1, 32'h0001_0000, NN + 3);
        run_scn(1'b0);
        @(negedge clk);
        set_one(2, 32'h0001_0000, NN + 3);
        cnt[2] = 0; rem[2] = 1; req = 4'b0100;
        repeat (100) @(negedge clk);
        check("busy_mid_wait", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs", outs(), 64'h0);
        req = '0;
        for (int j = 0; j < NL; j++) rem[j] = 0;
        mptr = 0; msticky = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        set_one(1, 32'h0004_0000, 20);
        cnt[2] = 1; lg_good[2] = 32'h0000_8000; lg_delay[2] = 30;
        run_scn(1'b0);
        set_one(3, 32'h0002_0001, NN + 3);
        run_scn(1'b0);

        // Randomized mixes.
        for (int r = 0; r < 10; r++) begin
            int any;
            thr = $urandom; is_pos = NL'($urandom);
            any = 0;
            for (int j = 0; j < NL; j++) begin
                int k;
                cnt[j] = $urandom_range(0, 2);
                any += cnt[j];
                lg_good[j] = ($urandom_range(0, 3) == 0) ? thr : $urandom;
                k = $urandom_range(0, 9);
                lg_delay[j] = (k == 0) ? -1 : (k == 1) ? TO : $urandom_range(1, 60);
            end
            if (any == 0) cnt[$urandom_range(0, NL - 1)] = 1;
            run_scn(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
